// File: rtl/alu_drv_pkg.sv
// alu_drv_pkg: shared types and constants for the ALU operation driver
package alu_drv_pkg;
    localparam int DW = 32;
    localparam int OW = 16;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    localparam logic [1:0] CLS_ARITH = 2'b00;
    localparam logic [1:0] CLS_LOGIC = 2'b01;
    localparam logic [1:0] CLS_CMP   = 2'b10;
    localparam logic [1:0] CLS_SHIFT = 2'b11;
    localparam logic [3:0] ADD     = 4'b0000;
    localparam logic [3:0] SUB     = 4'b0001;
    localparam logic [3:0] MUL     = 4'b0010;
    localparam logic [3:0] DIV     = 4'b0011;
    localparam logic [3:0] AND_OP  = 4'b0100;
    localparam logic [3:0] OR_OP   = 4'b0101;
    localparam logic [3:0] NAND_OP = 4'b0110;
    localparam logic [3:0] NOR_OP  = 4'b0111;
    localparam logic [3:0] CMP_NOP = 4'b1000;
    localparam logic [3:0] CMP_EQ  = 4'b1001;
    localparam logic [3:0] CMP_GT  = 4'b1010;
    localparam logic [3:0] CMP_LT  = 4'b1011;
    localparam logic [3:0] SHR_A   = 4'b1100;
    localparam logic [3:0] SHL_A   = 4'b1101;
    localparam logic [3:0] SHR_B   = 4'b1110;
    localparam logic [3:0] SHL_B   = 4'b1111;
    // Flag vectors are ordered {shift, cmp, logic, arith}, so bit index equals class code
    function automatic logic [3:0] cls_onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction
endpackage

// File: rtl/alu_drv_result_sel.sv
// alu_drv_result_sel: class-based result mux with zero-extension and flag check
module alu_drv_result_sel
    import alu_drv_pkg::*;
(
    input  logic [1:0]    i_cls,
    input  logic [DW-1:0] i_arith,
    input  logic [OW-1:0] i_logic,
    input  logic [OW-1:0] i_cmp,
    input  logic [OW-1:0] i_shift,
    input  logic [3:0]    i_flags,
    input  logic          i_carry,
    output logic [DW-1:0] o_data,
    output logic          o_carry,
    output logic          o_flag_ok,
    output logic          o_err
);
    always_comb begin
        o_data    = i_cls == CLS_ARITH ? i_arith :
                    i_cls == CLS_LOGIC ? DW'(i_logic) :
                    i_cls == CLS_CMP   ? DW'(i_cmp) : DW'(i_shift);
        o_carry   = (i_cls == CLS_ARITH) && i_carry;
        o_flag_ok = i_flags[i_cls];
        // Exactly the expected flag must be set; anything else is an error
        o_err     = i_flags != cls_onehot(i_cls);
    end
endmodule

// File: rtl/alu_op_driver.sv
// alu_op_driver: one-at-a-time request/response initiator for the registered ALU
// Optional flag-wait timeout enabled by defining ALU_DRV_TIMEOUT_EN.
module alu_op_driver
    import alu_drv_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int TIMEOUT = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [OW-1:0] req_a,
    input  logic [OW-1:0] req_b,
    input  logic [3:0]    req_fun,
    output logic [OW-1:0] alu_a,
    output logic [OW-1:0] alu_b,
    output logic [3:0]    alu_fun,
    input  logic [DW-1:0] arith_out,
    input  logic [OW-1:0] logic_out,
    input  logic [OW-1:0] cmp_out,
    input  logic [OW-1:0] shift_out,
    input  logic          arith_flag,
    input  logic          logic_flag,
    input  logic          cmp_flag,
    input  logic          shift_flag,
    input  logic          carry_out,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [1:0]    rsp_class,
    output logic          rsp_carry,
    output logic          rsp_err
);
    localparam int CW = $clog2(ALU_LAT + TIMEOUT + 2);

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic          w_accept, w_capture, w_tmo_done, w_tmo_fail;
    logic [DW-1:0] w_sel_data;
    logic          w_sel_carry, w_flag_ok, w_sel_err;

    alu_drv_result_sel u_sel (
        .i_cls     (alu_fun[3:2]),
        .i_arith   (arith_out),
        .i_logic   (logic_out),
        .i_cmp     (cmp_out),
        .i_shift   (shift_out),
        .i_flags   ({shift_flag, cmp_flag, logic_flag, arith_flag}),
        .i_carry   (carry_out),
        .o_data    (w_sel_data),
        .o_carry   (w_sel_carry),
        .o_flag_ok (w_flag_ok),
        .o_err     (w_sel_err)
    );

`ifdef ALU_DRV_TIMEOUT_EN
    logic [CW-1:0] r_tmo;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            r_tmo <= '0;
        else if (w_accept)
            r_tmo <= '0;
        else if (r_state == S_WAIT && r_cnt == '0 && !w_capture)
            r_tmo <= r_tmo + CW'(1);
    end
    assign w_tmo_done = r_tmo == CW'(TIMEOUT);
    assign w_tmo_fail = !w_flag_ok;
`else
    assign w_tmo_done = 1'b1;
    assign w_tmo_fail = 1'b0;
`endif

    always_comb begin
        w_accept  = (r_state == S_IDLE) && req_valid;
        w_capture = (r_state == S_WAIT) && (r_cnt == '0) && (w_flag_ok || w_tmo_done);
        w_next    = w_accept ? S_WAIT :
                    w_capture ? S_RESP :
                    (r_state == S_RESP && rsp_ready) ? S_IDLE : r_state;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_fun   <= '0;
            r_cnt     <= '0;
            rsp_data  <= '0;
            rsp_class <= '0;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                alu_a   <= req_a;
                alu_b   <= req_b;
                alu_fun <= req_fun;
                r_cnt   <= CW'(ALU_LAT);
            end else if (r_state == S_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_capture) begin
                rsp_data  <= w_tmo_fail ? '0 : w_sel_data;
                rsp_class <= alu_fun[3:2];
                rsp_carry <= !w_tmo_fail && w_sel_carry;
                rsp_err   <= w_sel_err;
            end
        end
    end

    // Gated by RST so req_ready reads 0 for the whole time reset is held
    assign req_ready = (r_state == S_IDLE) && RST;
    assign rsp_valid = r_state == S_RESP;
endmodule

// File: tb/tb_alu_op_driver.sv
// tb_alu_op_driver: directed self-checking bench for alu_op_driver
module tb_alu_op_driver;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [15:0] req_a = '0, req_b = '0;
    logic [3:0]  req_fun = '0;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_fun;
    logic [31:0] arith_out = '0;
    logic [15:0] logic_out = '0, cmp_out = '0, shift_out = '0;
    logic        arith_flag = 1'b0, logic_flag = 1'b0, cmp_flag = 1'b0, shift_flag = 1'b0;
    logic        carry_out = 1'b0;
    logic        rsp_valid, rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_class;
    logic        rsp_carry, rsp_err;
    int          total = 0;
    int          bad = 0;

    alu_op_driver #(.ALU_LAT(1), .TIMEOUT(8)) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_fun(req_fun),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
        .arith_out(arith_out), .logic_out(logic_out), .cmp_out(cmp_out), .shift_out(shift_out),
        .arith_flag(arith_flag), .logic_flag(logic_flag), .cmp_flag(cmp_flag), .shift_flag(shift_flag),
        .carry_out(carry_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_class(rsp_class), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_flags(input logic [3:0] f);
        {shift_flag, cmp_flag, logic_flag, arith_flag} = f;
    endtask

    // Present a request, accept it at edge 0, and return just after edge ALU_LAT+1
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun);
        req_a = a; req_b = b; req_fun = fun; req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        tick;
        tick;
    endtask

    initial begin
        tick;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_class", rsp_class, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_alu_a", alu_a, 0);
        RST = 1'b1;
        #1;
        chk("idle_req_ready", req_ready, 1);

        // 8 + 4 with per-edge latency checks
        arith_out = 32'd12; set_flags(4'b0001);
        req_a = 16'd8; req_b = 16'd4; req_fun = 4'b0000; req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        chk("add_alu_a", alu_a, 16'd8);
        chk("add_alu_b", alu_b, 16'd4);
        chk("add_alu_fun", alu_fun, 4'b0000);
        chk("add_busy", req_ready, 0);
        chk("add_e0_valid", rsp_valid, 0);
        tick;
        chk("add_e1_valid", rsp_valid, 0);
        tick;
        chk("add_e2_valid", rsp_valid, 1);
        chk("add_data", rsp_data, 32'h0000000C);
        chk("add_class", rsp_class, 2'b00);
        chk("add_err", rsp_err, 0);
        tick;
        chk("add_hs_valid", rsp_valid, 0);
        chk("add_hs_ready", req_ready, 1);

        // -8 * 4 with carry
        arith_out = 32'hFFFFFFE0; carry_out = 1'b1; set_flags(4'b0001);
        issue(16'hFFF8, 16'd4, 4'b0010);
        chk("mul_data", rsp_data, 32'hFFFFFFE0);
        chk("mul_class", rsp_class, 2'b00);
        chk("mul_carry", rsp_carry, 1);
        chk("mul_err", rsp_err, 0);
        tick;

        // 8 | 4 on the logic unit, carry must be masked
        arith_out = 32'h1234; logic_out = 16'd12; set_flags(4'b0010);
        issue(16'd8, 16'd4, 4'b0101);
        chk("or_data", rsp_data, 32'h0000000C);
        chk("or_class", rsp_class, 2'b01);
        chk("or_carry", rsp_carry, 0);
        chk("or_err", rsp_err, 0);
        tick;

        // Back-to-back with downstream stalled for 5 cycles
        carry_out = 1'b0; rsp_ready = 1'b0;
        shift_out = 16'h8001; set_flags(4'b1000);
        issue(16'd1, 16'd2, 4'b1100);
        req_a = 16'd5; req_b = 16'd6; req_fun = 4'b1001; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", rsp_valid, 1);
            chk("stall_data", rsp_data, 32'h00008001);
            chk("stall_class", rsp_class, 2'b11);
            chk("stall_ready", req_ready, 0);
            chk("stall_alu_a", alu_a, 16'd1);
            tick;
        end
        rsp_ready = 1'b1;
        tick;
        chk("b2b_hs_valid", rsp_valid, 0);
        chk("b2b_hs_alu_a", alu_a, 16'd1);
        tick;
        req_valid = 1'b0;
        chk("b2b_accept_alu_a", alu_a, 16'd5);
        chk("b2b_accept_fun", alu_fun, 4'b1001);
        chk("b2b_accept_ready", req_ready, 0);
        cmp_out = 16'd1; set_flags(4'b0100);
        tick;
        tick;
        chk("cmp_valid", rsp_valid, 1);
        chk("cmp_data", rsp_data, 32'h00000001);
        chk("cmp_class", rsp_class, 2'b10);
        chk("cmp_err", rsp_err, 0);
        tick;

        // Two flags raised on a compare
        set_flags(4'b1100);
        issue(16'd3, 16'd7, 4'b1010);
        chk("dup_valid", rsp_valid, 1);
        chk("dup_err", rsp_err, 1);
        chk("dup_class", rsp_class, 2'b10);
        tick;

        // Expected flag never arrives
        arith_out = 32'h55; set_flags(4'b0000);
`ifdef ALU_DRV_TIMEOUT_EN
        issue(16'd1, 16'd1, 4'b0000);
        chk("tmo_e2_valid", rsp_valid, 0);
        for (int i = 0; i < 7; i++) tick;
        chk("tmo_e9_valid", rsp_valid, 0);
        tick;
        chk("tmo_e10_valid", rsp_valid, 1);
        chk("tmo_err", rsp_err, 1);
        chk("tmo_data", rsp_data, 32'h0);
`else
        issue(16'd1, 16'd1, 4'b0000);
        chk("noflag_valid", rsp_valid, 1);
        chk("noflag_err", rsp_err, 1);
        chk("noflag_class", rsp_class, 2'b00);
`endif
        tick;

        // Reset pulsed while waiting on the ALU
        arith_out = 32'd5; set_flags(4'b0001);
        req_a = 16'd9; req_b = 16'd9; req_fun = 4'b0001; req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        RST = 1'b0;
        #1;
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_fun", alu_fun, 0);
        chk("mid_rst_data", rsp_data, 0);
        chk("mid_rst_err", rsp_err, 0);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_valid", rsp_valid, 0);
        tick;
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("post_rst_valid", rsp_valid, 0);
        end
        arith_out = 32'd12;
        issue(16'd8, 16'd4, 4'b0000);
        chk("post_rst_op_valid", rsp_valid, 1);
        chk("post_rst_op_data", rsp_data, 32'h0000000C);
        chk("post_rst_op_err", rsp_err, 0);
        tick;
        chk("post_rst_op_idle", req_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end
endmodule
